// File: rtl/spi_serf_regs_if.sv
// SPI pin bundle between the monarch and the serf.
interface spi_serf_regs_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_serf_regs.sv
// SPI serf terminating 16-bit frames into a 32x8 register file with a
// read-only WHO_AM_I location and a data-ready interrupt.
// All SPI pins are oversampled in the clk domain.
// Optional macro SPI_SERF_FRAMECHK_EN: defer write commit to SS_n rise and
// flag frames whose SCLK rise count is not exactly 16 on frame_err.
module spi_serf_regs #(
    parameter logic [7:0] WHO_AM_I     = 8'h6A,
    parameter logic [6:0] INT_CFG_ADDR = 7'h0D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_serf_regs_if.slave        spi,
    input  logic                  data_rdy,
    output logic                  INT,
    output logic                  wr_strb,
    output logic [6:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_err
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned NREG   = 32;
    localparam logic [ADDR_W-1:0] WHO_ADDR = 7'h0F;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t              state;
    logic [2:0]          ss_s;
    logic [2:0]          sclk_s;
    logic [1:0]          mosi_s;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   tx;
    logic                rw;
    logic [ADDR_W-1:0]   addr;
    logic                miso_q;
    logic                int_flag;
    logic [DATA_W-1:0]   regs [NREG];
`ifdef SPI_SERF_FRAMECHK_EN
    logic                extra;
`endif

    logic                ss_fall_c, ss_rise_c, sclk_rise_c, sclk_fall_c, mosi_c;
    logic [ADDR_W-1:0]   cmd_addr_c;
    logic [DATA_W-1:0]   rd_val_c;
    logic                commit_c;
    logic [DATA_W-1:0]   commit_data_c;
    logic                addr_ok_c;
    logic                read_done_c;
    logic                frame_err_c;

    assign spi.MISO = miso_q;

    // Two-flop synchronizers, plus a third stage on SS_n/SCLK for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_s   <= '0;
            sclk_s <= '0;
            mosi_s <= '0;
        end else begin
            ss_s   <= {ss_s[1:0], spi.SS_n};
            sclk_s <= {sclk_s[1:0], spi.SCLK};
            mosi_s <= {mosi_s[0], spi.MOSI};
        end
    end

    // Edge detection, read decode and commit qualification
    always_comb begin
        ss_fall_c   = ss_s[2] & ~ss_s[1];
        ss_rise_c   = ~ss_s[2] & ss_s[1];
        sclk_rise_c = ~sclk_s[2] & sclk_s[1];
        sclk_fall_c = sclk_s[2] & ~sclk_s[1];
        mosi_c      = mosi_s[1];

        cmd_addr_c = {shift[5:0], mosi_c};
        rd_val_c   = '0;
        if (cmd_addr_c == WHO_ADDR)
            rd_val_c = WHO_AM_I;
        else if (cmd_addr_c[6:5] == 2'b00)
            rd_val_c = regs[cmd_addr_c[4:0]];

        read_done_c = (state == DATA) && !ss_rise_c && sclk_rise_c &&
                      (cnt == CNT_W'(15)) && rw;
        addr_ok_c   = (addr != WHO_ADDR) && (addr[6:5] == 2'b00);
`ifdef SPI_SERF_FRAMECHK_EN
        commit_c      = (state == DONE) && ss_rise_c && !extra && !rw;
        commit_data_c = shift;
        frame_err_c   = ss_rise_c &&
                        ((((state == ADDR) || (state == DATA)) && (cnt != '0)) ||
                         ((state == DONE) && extra));
`else
        commit_c      = (state == DATA) && !ss_rise_c && sclk_rise_c &&
                        (cnt == CNT_W'(15)) && !rw;
        commit_data_c = {shift[6:0], mosi_c};
        frame_err_c   = 1'b0;
`endif
    end

    // Frame state machine: shifting, command latch and MISO drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shift  <= '0;
            tx     <= '0;
            rw     <= 1'b0;
            addr   <= '0;
            miso_q <= 1'b0;
`ifdef SPI_SERF_FRAMECHK_EN
            extra  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall_c) begin
                        cnt   <= '0;
                        shift <= '0;
                        tx    <= '0;
                        state <= ADDR;
`ifdef SPI_SERF_FRAMECHK_EN
                        extra <= 1'b0;
`endif
                    end
                end
                ADDR: begin
                    if (ss_rise_c) begin
                        state <= IDLE;
                    end else if (sclk_rise_c) begin
                        shift <= {shift[6:0], mosi_c};
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            rw    <= shift[6];
                            addr  <= cmd_addr_c;
                            tx    <= shift[6] ? rd_val_c : '0;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (ss_rise_c) begin
                        state  <= IDLE;
                        miso_q <= 1'b0;
                    end else begin
                        if (sclk_fall_c) begin
                            miso_q <= tx[7];
                            tx     <= {tx[6:0], 1'b0};
                        end
                        if (sclk_rise_c) begin
                            shift <= {shift[6:0], mosi_c};
                            cnt   <= cnt + CNT_W'(1);
                            if (cnt == CNT_W'(15))
                                state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (ss_rise_c) begin
                        state  <= IDLE;
                        miso_q <= 1'b0;
                    end
`ifdef SPI_SERF_FRAMECHK_EN
                    else if (sclk_rise_c) begin
                        extra <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file, write strobe, interrupt flag and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            wr_strb   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            int_flag  <= 1'b0;
            INT       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_strb <= 1'b0;
            if (commit_c && addr_ok_c) begin
                regs[addr[4:0]] <= commit_data_c;
                wr_strb         <= 1'b1;
                wr_addr         <= addr;
                wr_data         <= commit_data_c;
            end
            // A new sample wins over a read-completion clear in the same clk
            int_flag  <= data_rdy | (int_flag & ~read_done_c);
            INT       <= int_flag & regs[INT_CFG_ADDR[4:0]][1];
            frame_err <= frame_err_c;
        end
    end

endmodule

// File: tb/tb_spi_serf_regs.sv
// Self-checking bench for spi_serf_regs: directed table, corner-case
// sequences and randomized frames against a register-map model.
module tb_spi_serf_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_rdy;
    logic       INT;
    logic       wr_strb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    spi_serf_regs_if spi ();

    spi_serf_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi),
        .data_rdy  (data_rdy),
        .INT       (INT),
        .wr_strb   (wr_strb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int strb_cnt = 0;
    int err_cnt = 0;
    int exp_err = 0;

    logic [7:0] m_regs [32];

    typedef struct {
        logic [15:0] frm;
        logic [7:0]  exp_rd;
        int          exp_strb;
    } vec_t;

    vec_t tbl [10];

    always @(negedge clk) begin
        if (wr_strb)   strb_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a == 15) return 8'h6A;
        if (a < 32)  return m_regs[a];
        return 8'h00;
    endfunction

    function automatic bit m_writable(input int a);
        return (a != 15) && (a < 32);
    endfunction

    function automatic int frame_err_expected();
`ifdef SPI_SERF_FRAMECHK_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    // One monarch frame, SCLK half period 8 clk; MISO is sampled just before
    // each data-phase rise. rst_at > 0 pulses rst_n after that many rises.
    task automatic spi_frame(input logic [15:0] frm, input int nrise, input bit rdy_at_done,
                             input int rst_at, output logic [7:0] rd);
        rd = '0;
        spi.SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = (i < 16) ? frm[15-i] : 1'b0;
            repeat (8) @(negedge clk);
            if (i >= 8 && i < 16) rd[15-i] = spi.MISO;
            spi.SCLK = 1'b1;
            if (rdy_at_done && i == 15) begin
                repeat (2) @(negedge clk);
                data_rdy = 1'b1;
                @(negedge clk);
                data_rdy = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            if (rst_at > 0 && i == rst_at - 1) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check("rst_mid_miso", 16'(spi.MISO), 16'h0);
                check("rst_mid_int", 16'(INT), 16'h0);
                check("rst_mid_wr_addr", 16'(wr_addr), 16'h0);
                rst_n = 1'b1;
                @(negedge clk);
            end
        end
        spi.SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_rdy();
        data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
    endtask

    // Full frame checked against the model; updates the model on writes.
    task automatic model_frame(input logic [15:0] frm, input string name);
        logic [7:0] rd;
        int s0, a;
        a  = int'(frm[14:8]);
        s0 = strb_cnt;
        spi_frame(frm, 16, 1'b0, 0, rd);
        if (frm[15]) begin
            check({name, "_rd"}, 16'(rd), 16'(m_read(a)));
            check({name, "_rd_nostrb"}, 16'(strb_cnt - s0), 16'h0);
        end else begin
            check({name, "_strb"}, 16'(strb_cnt - s0), 16'(m_writable(a)));
            if (m_writable(a)) begin
                m_regs[a] = frm[7:0];
                check({name, "_wr_addr"}, 16'(wr_addr), 16'(frm[14:8]));
                check({name, "_wr_data"}, 16'(wr_data), 16'(frm[7:0]));
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        int s0, e0;
        logic [15:0] frm;

        tbl[0] = '{16'h8F00, 8'h6A, 0};
        tbl[1] = '{16'h05A5, 8'h00, 1};
        tbl[2] = '{16'h8500, 8'hA5, 0};
        tbl[3] = '{16'h0F33, 8'h00, 0};
        tbl[4] = '{16'h8F00, 8'h6A, 0};
        tbl[5] = '{16'hC000, 8'h00, 0};
        tbl[6] = '{16'h1F5C, 8'h00, 1};
        tbl[7] = '{16'h9F00, 8'h5C, 0};
        tbl[8] = '{16'h4011, 8'h00, 0};
        tbl[9] = '{16'hC000, 8'h00, 0};

        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        rst_n = 1'b0; data_rdy = 1'b0;
        spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("rst_miso", 16'(spi.MISO), 16'h0);
        check("rst_int", 16'(INT), 16'h0);
        check("rst_wr_strb", 16'(wr_strb), 16'h0);
        check("rst_wr_addr", 16'(wr_addr), 16'h0);
        check("rst_wr_data", 16'(wr_data), 16'h0);
        check("rst_frame_err", 16'(frame_err), 16'h0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            s0 = strb_cnt;
            spi_frame(tbl[i].frm, 16, 1'b0, 0, rd);
            if (tbl[i].frm[15]) check($sformatf("tbl%0d_rd", i), 16'(rd), 16'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_strb", i), 16'(strb_cnt - s0), 16'(tbl[i].exp_strb));
            if (tbl[i].exp_strb != 0) begin
                check($sformatf("tbl%0d_wr_addr", i), 16'(wr_addr), 16'(tbl[i].frm[14:8]));
                check($sformatf("tbl%0d_wr_data", i), 16'(wr_data), 16'(tbl[i].frm[7:0]));
                m_regs[tbl[i].frm[12:8]] = tbl[i].frm[7:0];
            end
        end

        // Interrupt enable, set latency and clear on read completion
        model_frame(16'h0D02, "int_cfg");
        check("int_before_rdy", 16'(INT), 16'h0);
        pulse_rdy();
        check("int_lat0", 16'(INT), 16'h0);
        @(negedge clk);
        check("int_set", 16'(INT), 16'h1);
        model_frame(16'h8D00, "int_rd");
        check("int_cleared", 16'(INT), 16'h0);

        // data_rdy coincident with read reaching DONE: set wins
        pulse_rdy();
        repeat (2) @(negedge clk);
        spi_frame(16'h8D00, 16, 1'b1, 0, rd);
        check("coll_rd", 16'(rd), 16'h02);
        check("coll_int", 16'(INT), 16'h1);
        spi_frame(16'h8D00, 16, 1'b0, 0, rd);
        check("coll_int_clr", 16'(INT), 16'h0);

        // Aborted frame after 10 rises
        model_frame(16'h0155, "abort_pre");
        s0 = strb_cnt; e0 = err_cnt;
        spi_frame(16'h0177, 10, 1'b0, 0, rd);
        exp_err += frame_err_expected();
        check("abort_strb", 16'(strb_cnt - s0), 16'h0);
        check("abort_err", 16'(err_cnt - e0), 16'(frame_err_expected()));
        model_frame(16'h8100, "abort_post");

        // Reset in the middle of a write frame
        model_frame(16'h0211, "rst_pre");
        pulse_rdy();
        repeat (2) @(negedge clk);
        check("rst_pre_int", 16'(INT), 16'h1);
        s0 = strb_cnt;
        spi_frame(16'h0299, 16, 1'b0, 10, rd);
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        check("rst_mid_strb", 16'(strb_cnt - s0), 16'h0);
        model_frame(16'h8200, "rst_reg2");
        model_frame(16'h8D00, "rst_cfg");
        model_frame(16'h0299, "rst_next_wr");
        model_frame(16'h8200, "rst_next_rd");

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            frm[15]   = 1'($urandom_range(0, 1));
            frm[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(32, 127))
                                                    : 7'($urandom_range(0, 31));
            frm[7:0]  = 8'($urandom);
            if (frm[14:8] == 7'h0D) frm[7:0] = frm[7:0] & 8'hFD;
            model_frame(frm, $sformatf("rnd%0d", n));
        end

        check("frame_err_total", 16'(err_cnt), 16'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
